// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code decoder: prefix bytes, keyboard
// housekeeping bytes, parser states and the buffered key-event record.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Keyboard status/response bytes that never start a key sequence
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR_LO = 8'h00;
  localparam logic [7:0] PS2_ERR_HI = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
  endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Set-2 scan code to ASCII lookup (lowercase letters, digits, space, enter,
// backspace); every other code yields 0. Purely combinational.
module ps2_ascii_rom (
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = 8'h61;
      8'h32: ascii = 8'h62;
      8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;
      8'h24: ascii = 8'h65;
      8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;
      8'h33: ascii = 8'h68;
      8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;
      8'h42: ascii = 8'h6B;
      8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;
      8'h31: ascii = 8'h6E;
      8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;
      8'h15: ascii = 8'h71;
      8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;
      8'h2C: ascii = 8'h74;
      8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;
      8'h1D: ascii = 8'h77;
      8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;
      8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;
      8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34;
      8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;
      8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      8'h66: ascii = 8'h08;
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns validated PS/2 set-2 bytes into press/release events, filters
// typematic repeats, counts presses and queues events behind ready/valid.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sc_valid,
  input  logic [7:0]       sc_data,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic [7:0]       ev_ascii,
  output logic [CNT_W-1:0] press_cnt,
  output logic             key_held,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             key_held_q, key_held_d;
  logic [8:0]       held_q, held_d;
  logic             overflow_q, overflow_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  ps2_event_t       mem_q [FIFO_DEPTH];
  ps2_event_t       mem_d [FIFO_DEPTH];

  logic       got_byte, got_ext, got_brk;
  logic       is_repeat, push, pop, do_push, empty, full;
  ps2_event_t ev_in, head;
  logic [7:0] rom_ascii;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      press_cnt_q <= '0;
      key_held_q  <= 1'b0;
      held_q      <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      press_cnt_q <= press_cnt_d;
      key_held_q  <= key_held_d;
      held_q      <= held_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Prefix parser; got_byte marks the byte that completes a key sequence
  always_comb begin
    state_d  = state_q;
    got_byte = 1'b0;
    got_ext  = 1'b0;
    got_brk  = 1'b0;
    if (sc_valid) begin
      unique case (state_q)
        IDLE: begin
          if (sc_data == PS2_EXT)      state_d = EXT;
          else if (sc_data == PS2_BRK) state_d = BRK;
          else if (!is_ignored(sc_data)) got_byte = 1'b1;
        end
        EXT: begin
          if (sc_data == PS2_BRK)      state_d = EXT_BRK;
          else if (sc_data == PS2_EXT) state_d = EXT;
          else begin
            got_byte = 1'b1;
            got_ext  = 1'b1;
            state_d  = IDLE;
          end
        end
        BRK: begin
          state_d = IDLE;
          if (sc_data != PS2_EXT && sc_data != PS2_BRK) begin
            got_byte = 1'b1;
            got_brk  = 1'b1;
          end
        end
        EXT_BRK: begin
          state_d = IDLE;
          if (sc_data != PS2_EXT && sc_data != PS2_BRK) begin
            got_byte = 1'b1;
            got_ext  = 1'b1;
            got_brk  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ev_in       = {got_ext, got_brk, sc_data};
    is_repeat   = key_held_q && (held_q == {got_ext, sc_data});
    push        = got_byte && (got_brk || !is_repeat);
    press_cnt_d = press_cnt_q;
    key_held_d  = key_held_q;
    held_d      = held_q;
    if (got_byte && !got_brk && !is_repeat) begin
      press_cnt_d = press_cnt_q + CNT_W'(1);
      key_held_d  = 1'b1;
      held_d      = {got_ext, sc_data};
    end else if (got_byte && got_brk && (held_q == {got_ext, sc_data})) begin
      key_held_d = 1'b0;
    end
  end

  // A push into a full FIFO only survives if the head leaves in the same cycle
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !empty && ev_ready;
    do_push    = push && (!full || pop);
    overflow_d = overflow_q || (push && full && !pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = ev_in;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  ps2_ascii_rom u_ascii_rom (
    .code  (head.code),
    .ascii (rom_ascii)
  );

  assign ev_valid  = !empty;
  assign ev_code   = head.code;
  assign ev_ext    = head.ext;
  assign ev_break  = head.brk;
  assign ev_ascii  = head.ext ? 8'h00 : rom_ascii;
  assign press_cnt = press_cnt_q;
  assign key_held  = key_held_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits directly downstream of the PS/2 serial receiver; consumes validated scan-code bytes (set 2).
- Assembles multi-byte sequences (E0 extended prefix, F0 break prefix) into key events.
- Suppresses typematic repeats and counts distinct key presses.
- Buffers events in a small FIFO for the CPU/display side, with ready/valid output.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2.
- CNT_W, 8, width of the press counter.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- sc_valid  in  1  one-cycle strobe: sc_data holds a received, parity-checked byte.
- sc_data  in  8  scan-code byte.
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer accepts the head event when ev_valid & ev_ready.
- ev_code  out  8  key scan code of the head event (prefixes stripped).
- ev_ext  out  1  head event was E0-prefixed.
- ev_break  out  1  head event is a release (1) or press (0).
- ev_ascii  out  8  ASCII of ev_code; 0 when ev_ext=1 or the code is unmapped.
- press_cnt  out  CNT_W  count of accepted distinct presses; wraps.
- key_held  out  1  a key is currently held down.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE; FIFO empty.
  - ev_valid=0, press_cnt=0, key_held=0, overflow=0, held code/ext=0.
- Parser FSM advances only on cycles with sc_valid=1:
  - IDLE: E0->EXT; F0->BRK; any other byte B -> emit make(B, ext=0); stay in IDLE.
  - EXT: F0->EXT_BRK; E0->EXT (duplicate prefix is ignored); other B -> emit make(B, ext=1), go to IDLE.
  - BRK: E0/F0 -> IDLE, discarded (malformed); other B -> emit break(B, ext=0), go to IDLE.
  - EXT_BRK: E0/F0 -> IDLE, discarded; other B -> emit break(B, ext=1), go to IDLE.
  - Bytes AA, FA, EE, FE, 00 and FF are, in IDLE only, dropped with no event and no state change.
- Make handling:
  - If key_held=1 and {ext,B} equals the held code, the make is a typematic repeat: drop it, no event, no count.
  - Otherwise push a press event, press_cnt += 1 (modulo 2^CNT_W), key_held=1, held code := {ext,B}.
- Break handling:
  - Always push a release event.
  - If {ext,B} equals the held code, key_held=0.
  - If it does not match, key_held is unchanged.
- Single-key tracking only. A new make overwrites the held code. Releasing the earlier key does not clear key_held.
- Timing:
  - Event push occurs in the same cycle as the final sc_valid byte; ev_valid rises the next cycle.
  - press_cnt and key_held update in that same cycle.
- FIFO:
  - Entry = {ext, break, code[7:0]}, 10 bits.
  - ev_code/ev_ext/ev_break/ev_ascii are combinational from the head entry; they are don't-care when ev_valid=0.
  - Pop on ev_valid & ev_ready.
  - Push when full and no pop in that cycle: event dropped, overflow:=1. overflow clears only on reset.
  - Push and pop in the same cycle while full: both succeed, occupancy unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only (no bypass).
  - Pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit. Full = MSBs differ and lower bits are equal.
- ASCII map:
  - Letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A -> 'a'..'z' (lowercase).
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 -> '0'..'9'.
  - 29->20h (space), 5A->0Dh (enter), 66->08h (backspace).
  - All other codes map to 0.
- Mid-operation reset clears everything immediately. A partial prefix sequence is lost.

Decomposition:
- Shared package ps2_pkg:
  - Prefix constants PS2_EXT=8'hE0, PS2_BRK=8'hF0.
  - Ignored-byte constants.
  - Parser state enum {IDLE, EXT, BRK, EXT_BRK}.
  - Event struct {ext, brk, code}.
- Sub-module ps2_ascii_rom: purely combinational 8-bit code -> 8-bit ASCII case table, reusable by the display path.
- FIFO logic stays inline.

Test Plan:
- Press and release 'a': send 1C, then F0, 1C -> two events {1C,ext0,brk0,ascii 61h} then {1C,ext0,brk1}; press_cnt=1; key_held goes 1 then 0.
- Extended key: send E0,75 then E0,F0,75 -> events {75,ext1,brk0,ascii 0} and {75,ext1,brk1}; press_cnt=1.
- Typematic: send 1C five times, then F0,1C -> only one press event and one release; press_cnt=1.
- Overflow: hold ev_ready=0 and send 9 distinct makes (16,1E,26,25,2E,36,3D,3E,46) -> 8 events buffered, overflow=1; drain yields 16..3E in order, ascii '1'..'8'.
- Full push+pop: with 8 entries and ev_ready=1, send 45 in the same cycle as a pop -> occupancy stays 8, overflow stays 0, 45 appears last.
- Reset mid-sequence: send E0,F0, assert resetn=0, release, then send 1C -> single make event {1C,ext0}; press_cnt=1.
